// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access encodings,
// FSM states and lane sizing.
package lsu_pkg;

  localparam int DW_BYTES = 8;

  typedef enum logic [2:0] {
    LS_B   = 3'b000,
    LS_H   = 3'b001,
    LS_W   = 3'b010,
    LS_D   = 3'b011,
    LS_BU  = 3'b100,
    LS_HU  = 3'b101,
    LS_WU  = 3'b110,
    LS_ILL = 3'b111
  } func3_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] func3);
    logic [3:0] n;
    case (func3[1:0])
      2'b00:   n = 4'd1;
      2'b01:   n = 4'd2;
      2'b10:   n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  // Offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] alignMask(input logic [2:0] func3);
    logic [2:0] m;
    case (func3[1:0])
      2'b00:   m = 3'b000;
      2'b01:   m = 3'b001;
      2'b10:   m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Control-unit and data-memory signals of the load/store unit.
interface lsu_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) ();
  logic              start;
  logic              is_store;
  logic [2:0]        func3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output start, is_store, func3, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_addr, mem_wr, mem_wdata
  );

  modport slave (
    input  start, is_store, func3, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_merge.sv
// Byte-lane datapath: extract/extend a load field from a doubleword and
// merge store bytes into an old doubleword.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [2:0]  func3,
  input  logic [63:0] oldWord,
  input  logic [63:0] wdata,
  output logic [63:0] loadVal,
  output logic [63:0] mergedWord
);

  logic [5:0]  shAmt_s;
  logic [63:0] field_s;
  logic [63:0] laneMask_s;

  assign shAmt_s = {off, 3'b000};

  // Load field: shift the addressed lane down, then sign/zero-extend.
  always_comb begin
    field_s = oldWord >> shAmt_s;
    case (func3)
      LS_B:    loadVal = {{56{field_s[7]}}, field_s[7:0]};
      LS_H:    loadVal = {{48{field_s[15]}}, field_s[15:0]};
      LS_W:    loadVal = {{32{field_s[31]}}, field_s[31:0]};
      LS_D:    loadVal = field_s;
      LS_BU:   loadVal = {56'd0, field_s[7:0]};
      LS_HU:   loadVal = {48'd0, field_s[15:0]};
      LS_WU:   loadVal = {32'd0, field_s[31:0]};
      default: loadVal = 64'd0;
    endcase
  end

  // Store merge: replace bytes [off, off+size) with the low bytes of wdata.
  always_comb begin
    if (size_bytes(func3) == 4'(DW_BYTES)) begin
      laneMask_s = {64{1'b1}};
    end else begin
      laneMask_s = ((64'd1 << {size_bytes(func3), 3'b000}) - 64'd1) << shAmt_s;
    end
    mergedWord = (oldWord & ~laneMask_s) | ((wdata << shAmt_s) & laneMask_s);
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit with read-modify-write for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating the offset.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  state_e            state_r;
  logic              isStore_r;
  logic [2:0]        func3_r;
  logic [2:0]        off_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic [DATA_W-1:0] memWdata_r;
  logic [ADDR_W-1:0] memAddr_r;
  logic              done_r;
  logic              err_r;
  logic              memWr_r;

  logic              illegal_s;
  logic              errReq_s;
  logic [2:0]        effOff_s;
  logic [DATA_W-1:0] loadVal_s;
  logic [DATA_W-1:0] mergedWord_s;

  // Request decode: illegal encodings, alignment and effective lane offset.
  always_comb begin
    if (bus.is_store) begin
      illegal_s = bus.func3[2];
    end else begin
      illegal_s = (bus.func3 == LS_ILL);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    errReq_s = illegal_s | (|(bus.addr[2:0] & alignMask(bus.func3)));
    effOff_s = bus.addr[2:0];
`else
    errReq_s = illegal_s;
    effOff_s = bus.addr[2:0] & ~alignMask(bus.func3);
`endif
  end

  // mem_rdata is only consumed in CAP, where it holds the addressed doubleword.
  lsu_lane_merge u_lane_merge (
    .off        (off_r),
    .func3      (func3_r),
    .oldWord    (bus.mem_rdata),
    .wdata      (wdata_r),
    .loadVal    (loadVal_s),
    .mergedWord (mergedWord_s)
  );

  // Access sequencer with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      isStore_r  <= 1'b0;
      func3_r    <= 3'b000;
      off_r      <= 3'b000;
      wdata_r    <= '0;
      rdata_r    <= '0;
      memWdata_r <= '0;
      memAddr_r  <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      memWr_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          memWr_r <= 1'b0;
          if (bus.start) begin
            isStore_r <= bus.is_store;
            func3_r   <= bus.func3;
            off_r     <= effOff_s;
            wdata_r   <= bus.wdata;
            memAddr_r <= {bus.addr[ADDR_W-1:3], 3'b000};
            if (errReq_s) begin
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              state_r <= DONE;
            end else if (bus.is_store && (bus.func3 == LS_D)) begin
              memWdata_r <= bus.wdata;
              memWr_r    <= 1'b1;
              state_r    <= WR;
            end else begin
              state_r <= RD;
            end
          end else begin
            memAddr_r <= '0;
            state_r   <= IDLE;
          end
        end
        RD: state_r <= CAP;
        CAP: begin
          if (isStore_r) begin
            memWdata_r <= mergedWord_s;
            memWr_r    <= 1'b1;
            state_r    <= WR;
          end else begin
            rdata_r <= loadVal_s;
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        WR: begin
          memWr_r <= 1'b0;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done_r    <= 1'b0;
          err_r     <= 1'b0;
          memAddr_r <= '0;
          state_r   <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_r != IDLE);
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_addr  = memAddr_r;
  assign bus.mem_wr    = memWr_r;
  assign bus.mem_wdata = memWdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, random ops against a byte-array
// model, held-start and mid-access reset sequences.
module tb_load_store_unit;

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] expRd;
    bit          expErr;
    int          expDone;
    int          expWrCyc;
    logic [63:0] expMem;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_if bus ();
  load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));

  logic [63:0] mem [0:31];
  logic        preWr = 1'b0;
  logic [4:0]  preIdx = 5'd0;
  logic [63:0] preData = 64'd0;
  int          wrTotal = 0;
  int          errBad = 0;

  // Synchronous data memory: one-cycle read latency, write on mem_wr.
  always @(posedge clk) begin
    if (preWr) mem[preIdx] <= preData;
    else if (bus.mem_wr) mem[bus.mem_addr[7:3]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[7:3]];
    if (bus.mem_wr) wrTotal <= wrTotal + 1;
  end

  always @(negedge clk) if (bus.err && !bus.done) errBad <= errBad + 1;

  logic [7:0]  refByte [0:255];
  logic [63:0] lastRd;
  int vecCount = 0;
  int missCount = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] refWord(input int a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = refByte[(a & ~7) + i];
    return v;
  endfunction

  task automatic modelOp(input bit st, input logic [2:0] f3, input int a, input logic [63:0] wd,
                         output int eDone, output bit eErr, output int eWrCyc);
    int n, off, ea;
    bit illegal, bad;
    logic [63:0] v;
    n = 1 << f3[1:0];
    off = a % 8;
    illegal = st ? f3[2] : (f3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = illegal || (off % n != 0);
    ea = a;
`else
    bad = illegal;
    ea = a - (off % n);
`endif
    eWrCyc = 0;
    eErr = 1'b0;
    if (bad) begin
      eDone = 1;
      eErr = 1'b1;
    end else if (!st) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = refByte[ea + i];
      if (!f3[2] && n < 8 && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      lastRd = v;
      eDone = 3;
    end else begin
      for (int i = 0; i < n; i++) refByte[ea + i] = wd[8*i +: 8];
      eDone = (n == 8) ? 2 : 4;
      eWrCyc = (n == 8) ? 1 : 3;
    end
  endtask

  task automatic runOp(input bit st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                       input bit hold, output int dCyc, output bit eSeen, output logic [63:0] rd,
                       output int wCyc, output int wCnt);
    @(negedge clk);
    check("idle_before_start", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b1; bus.is_store = st; bus.func3 = f3; bus.addr = a; bus.wdata = wd;
    dCyc = 0; eSeen = 1'b0; rd = bus.rdata; wCyc = 0; wCnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (bus.mem_wr) begin wCnt++; wCyc = k; end
      if (bus.done) begin dCyc = k; eSeen = bus.err; rd = bus.rdata; break; end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    vec_t tbl [9];
    int dC, wC, wN, eD, eW, a, cnt, wrBefore;
    bit eS, eE, st;
    logic [2:0] f3;
    logic [63:0] rd, w, wd;

    reset = 1'b0;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.func3 = 3'b000; bus.addr = 64'd0; bus.wdata = 64'd0;
    for (int i = 0; i < 32; i++) begin
      w = (i == 2) ? 64'h8877665544332211 : {$urandom, $urandom};
      @(negedge clk);
      preWr = 1'b1; preIdx = 5'(i); preData = w;
      for (int j = 0; j < 8; j++) refByte[i*8 + j] = w[8*j +: 8];
    end
    @(negedge clk);
    preWr = 1'b0;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_err", {63'd0, bus.err}, 64'd0);
    check("rst_rdata", bus.rdata, 64'd0);
    check("rst_mem_wr", {63'd0, bus.mem_wr}, 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_mem_wdata", bus.mem_wdata, 64'd0);
    reset = 1'b1;
    lastRd = 64'd0;

    tbl[0] = '{1'b0, 3'b000, 64'h13, 64'h0, 64'h0000000000000044, 1'b0, 3, 0, 64'h8877665544332211};
    tbl[1] = '{1'b0, 3'b000, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 3, 0, 64'h8877665544332211};
    tbl[2] = '{1'b0, 3'b100, 64'h17, 64'h0, 64'h0000000000000088, 1'b0, 3, 0, 64'h8877665544332211};
    tbl[3] = '{1'b1, 3'b001, 64'h12, 64'hABCD, 64'h0000000000000088, 1'b0, 4, 3, 64'h88776655ABCD2211};
    tbl[4] = '{1'b1, 3'b011, 64'h20, 64'h0123456789ABCDEF, 64'h0000000000000088, 1'b0, 2, 1, 64'h0123456789ABCDEF};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[5] = '{1'b0, 3'b010, 64'h22, 64'h0, 64'h0000000000000088, 1'b1, 1, 0, 64'h0123456789ABCDEF};
    tbl[6] = '{1'b0, 3'b011, 64'h21, 64'h0, 64'h0000000000000088, 1'b1, 1, 0, 64'h0123456789ABCDEF};
    tbl[7] = '{1'b1, 3'b100, 64'h10, 64'h55, 64'h0000000000000088, 1'b1, 1, 0, 64'h88776655ABCD2211};
    tbl[8] = '{1'b0, 3'b111, 64'h10, 64'h0, 64'h0000000000000088, 1'b1, 1, 0, 64'h88776655ABCD2211};
`else
    tbl[5] = '{1'b0, 3'b010, 64'h22, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, 3, 0, 64'h0123456789ABCDEF};
    tbl[6] = '{1'b0, 3'b011, 64'h21, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3, 0, 64'h0123456789ABCDEF};
    tbl[7] = '{1'b1, 3'b100, 64'h10, 64'h55, 64'h0123456789ABCDEF, 1'b1, 1, 0, 64'h88776655ABCD2211};
    tbl[8] = '{1'b0, 3'b111, 64'h10, 64'h0, 64'h0123456789ABCDEF, 1'b1, 1, 0, 64'h88776655ABCD2211};
`endif

    for (int i = 0; i < 9; i++) begin
      modelOp(tbl[i].st, tbl[i].f3, int'(tbl[i].addr), tbl[i].wdata, eD, eE, eW);
      runOp(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 1'b0, dC, eS, rd, wC, wN);
      check($sformatf("t%0d_done_cyc", i), 64'(dC), 64'(tbl[i].expDone));
      check($sformatf("t%0d_err", i), {63'd0, eS}, {63'd0, tbl[i].expErr});
      check($sformatf("t%0d_rdata", i), rd, tbl[i].expRd);
      check($sformatf("t%0d_wr_cyc", i), 64'(wC), 64'(tbl[i].expWrCyc));
      check($sformatf("t%0d_wr_cnt", i), 64'(wN), (tbl[i].expWrCyc != 0) ? 64'd1 : 64'd0);
      check($sformatf("t%0d_mem", i), mem[tbl[i].addr[7:3]], tbl[i].expMem);
    end

    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = int'($urandom_range(0, 255));
      wd = {$urandom, $urandom};
      modelOp(st, f3, a, wd, eD, eE, eW);
      runOp(st, f3, 64'(a), wd, 1'b0, dC, eS, rd, wC, wN);
      check($sformatf("r%0d_done_cyc", i), 64'(dC), 64'(eD));
      check($sformatf("r%0d_err", i), {63'd0, eS}, {63'd0, eE});
      check($sformatf("r%0d_rdata", i), rd, lastRd);
      check($sformatf("r%0d_wr_cyc", i), 64'(wC), 64'(eW));
      check($sformatf("r%0d_wr_cnt", i), 64'(wN), (eW != 0) ? 64'd1 : 64'd0);
      check($sformatf("r%0d_mem", i), mem[a / 8], refWord(a));
    end

    // start held high for the whole load: exactly one access
    modelOp(1'b0, 3'b000, 32'h10, 64'd0, eD, eE, eW);
    runOp(1'b0, 3'b000, 64'h10, 64'd0, 1'b1, dC, eS, rd, wC, wN);
    check("held_done_cyc", 64'(dC), 64'd3);
    check("held_rdata", rd, lastRd);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("held_extra_done", 64'(cnt), 64'd0);
    check("held_busy_after", {63'd0, bus.busy}, 64'd0);

    // reset during CAP of a byte store
    wrBefore = wrTotal;
    w = refWord(32'h30);
    @(negedge clk);
    bus.start = 1'b1; bus.is_store = 1'b1; bus.func3 = 3'b000; bus.addr = 64'h33; bus.wdata = 64'h5A;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_mid_busy_pre", {63'd0, bus.busy}, 64'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_mid_done", {63'd0, bus.done}, 64'd0);
    check("rst_mid_err", {63'd0, bus.err}, 64'd0);
    check("rst_mid_rdata", bus.rdata, 64'd0);
    check("rst_mid_mem_wr", {63'd0, bus.mem_wr}, 64'd0);
    check("rst_mid_mem_addr", bus.mem_addr, 64'd0);
    check("rst_mid_mem_wdata", bus.mem_wdata, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    lastRd = 64'd0;
    check("rst_mid_no_write", 64'(wrTotal - wrBefore), 64'd0);
    check("rst_mid_mem", mem[6], w);
    modelOp(1'b0, 3'b000, 32'h33, 64'd0, eD, eE, eW);
    runOp(1'b0, 3'b000, 64'h33, 64'd0, 1'b0, dC, eS, rd, wC, wN);
    check("post_rst_done_cyc", 64'(dC), 64'd3);
    check("post_rst_rdata", rd, lastRd);
    check("post_rst_err", {63'd0, eS}, 64'd0);

    repeat (2) @(negedge clk);
    check("err_without_done", 64'(errBad), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle load/store unit between the datapath's ALUOut/B registers and the 64-bit data memory. It accepts one access per start pulse. Loads extract and sign/zero-extend a byte, half, word or doubleword into a 64-bit result for the register-bank write-data mux. Stores write a doubleword directly, and perform byte/half/word stores by read-modify-write of the enclosing doubleword. The control unit sequences it through a start/done handshake.

## Interface
Parameters:
- ADDR_W, 64, byte-address width.
- DATA_W, 64, memory word width; only 64 is supported.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  access request; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- func3  in  3  access size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- addr  in  ADDR_W  byte address (ALUOut).
- wdata  in  DATA_W  store data (B register); the low bytes are used.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned access or illegal func3.
- rdata  out  DATA_W  extended load result; holds until the next load completes.
- mem_addr  out  ADDR_W  doubleword-aligned address: {addr[63:3],3'b000}.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  merged write doubleword.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr is presented.

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE with start=1 latches is_store, func3, addr and wdata. Start is ignored in every other state.
- Lane offset is off = addr[2:0]. Alignment requirements: h needs off[0]=0, w needs off[1:0]=0, d needs off=0.
- Illegal func3:
  - Store with func3[2]=1 is illegal.
  - Load with func3=111 is illegal.
- Illegal or misaligned access: IDLE→DONE with err=1. There is no memory access, and rdata is unchanged.
- Load: IDLE→RD→CAP→DONE.
  - CAP captures mem_rdata.
  - The field is mem_rdata >> (8*off), truncated to the access size.
  - Sign-extend for b/h/w; zero-extend for bu/hu/wu/d.
- Store d: IDLE→WR→DONE. mem_wdata = wdata.
- Store b/h/w: IDLE→RD→CAP→WR→DONE.
  - CAP latches the old doubleword.
  - WR drives mem_wdata = old word with bytes [off, off+size) replaced by the low bytes of wdata.
- mem_wr=1 only in WR. mem_addr holds the latched aligned address while busy, and 0 in IDLE.
- DONE→IDLE unconditionally.
- Reset values: state IDLE, busy 0, done 0, err 0, rdata 0, mem_wr 0, mem_addr 0, mem_wdata 0.

## Timing
- Cycle 0 is the edge on which start is sampled.
- Aligned load: RD in cycle 1, CAP in cycle 2, done=1 in cycle 3. rdata is valid from cycle 3. Latency 3.
- Sub-word store: mem_wr=1 in cycle 3, done in cycle 4.
- Doubleword store: mem_wr=1 in cycle 1, done in cycle 2.
- Error: done=err=1 in cycle 1.
- Back-to-back: start may be asserted in the cycle after done, once the unit is in IDLE. The earliest accepted start is then the following edge.
- Reset asserted mid-operation:
  - All outputs return to their reset values asynchronously.
  - A store aborted before the WR edge leaves memory unmodified.
  - No done pulse is produced.
- err is 0 whenever done is 0.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned accesses take the error path described above.
- LSU_MISALIGN_TRAP_EN undefined:
  - The offset is truncated to natural alignment: off &= ~(size-1).
  - The access proceeds normally.
  - err is raised only for illegal func3.

## Structure
- Shared package lsu_pkg:
  - func3 encoding enum (LS_B … LS_WU).
  - State enum.
  - Function size_bytes(func3).
  - Constant DW_BYTES = 8.
- Sub-module lsu_lane_merge (combinational): performs byte-lane extract/extend for loads and byte-lane merge for stores. Inputs are off, func3, old word and wdata. Outputs are the load value and the merged word.
- The FSM and all registers live in load_store_unit.

## Test plan
- Load: memory[0x10] = 0x8877665544332211; lb at 0x13 → done in cycle 3, rdata = 0x0000000000000044. lb at 0x17 → 0xFFFFFFFFFFFFFF88. lbu at 0x17 → 0x88.
- Store: sh wdata = 0xABCD at 0x12 on memory[0x10] = 0x8877665544332211 → one write in cycle 3 of 0x88776655ABCD2211, done in cycle 4.
- Doubleword store: sd 0x0123456789ABCDEF at 0x20 → mem_wr only in cycle 1, no read cycle, done in cycle 2.
- Misaligned: lw at 0x22 with LSU_MISALIGN_TRAP_EN → done=err=1 in cycle 1, mem_wr never asserted, rdata unchanged. Without the macro → word read from offset 0; ld at 0x21 reads offset 0.
- Illegal func3 and busy: store with func3 = 100 → err=1. start held high through a load → exactly one access. Next start accepted right after DONE.
- Reset: reset low during CAP of a sub-word store → mem_wr never asserted, memory unchanged, outputs at 0, next access completes normally.
